z3_target_ctrl: RTL and testbench
=================================

// Module: z3_target_ctrl
// PURPOSE
//  Parametrised Zorro III slave-cycle controller for the A4092 family; successor to the fixed 4-state DTACK logic.
//  Synchronises FCS_n/DS_n, claims cycles whose latched address hits one of NUM_REGIONS base/mask windows,
//  issues a one-hot request to the owning region (ROM, SID, SCSI, INTREG, autoconfig, ...), collects its ack, drives DTACK_n.
//  Sits between the address latch and the per-region access blocks.
// PARAMETERS
//  NUM_REGIONS    5                  number of decoded target regions (1..8)
//  REGION_BASE    {NUM_REGIONS{28'h0}} packed NUM_REGIONS*28 bits; region i base at [28*i +: 28]
//  REGION_MASK    {NUM_REGIONS{28'h0}} packed, same layout; 1 = bit compared
//  SYNC_STAGES    2                  synchroniser depth for FCS_n and DS_n (>=2)
//  TIMEOUT_CYCLES 255                DATA-state cycles before forced termination (Z3_TIMEOUT_EN only)
// PORTS
//  CLK          in   1   board clock
//  IORST_n      in   1   async active-low reset
//  FCS_n        in   1   Zorro full cycle strobe, asynchronous
//  DS_n         in   4   Zorro data strobes, asynchronous
//  READ         in   1   1 = read cycle
//  FC           in   3   function code; valid space = FC[1]^FC[0]
//  addr         in   28  latched cycle address, stable while FCS_n low
//  region_en    in   NUM_REGIONS   per-region enable (e.g. configured, !shutup)
//  region_req   out  NUM_REGIONS   one-hot request to owning region
//  region_ack   in   NUM_REGIONS   region done; sampled only for the selected region
//  dtack_oe     out  1   drive DTACK_n low (pad tri-stated otherwise)
//  doe          out  1   data output enable toward local bus
//  slave_active out  1   cycle claimed (drives SLAVE_n externally)
//  timeout_err  out  1   sticky: a cycle was force-terminated
//  err_clr      in   1   clears timeout_err
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, sync chains all 1s.
//  - fcs = FCS_n after SYNC_STAGES flops; ds_any = any DS_n bit low after sync.
//  - hit[i] = region_en[i] && ((addr ^ base_i) & mask_i) == 0; lowest index wins on overlap.
//  - IDLE: on !fcs_n && validspace && |hit -> START; latch sel = one-hot winner; slave_active=1.
//    No hit or invalid space -> stay IDLE; no outputs asserted (other board may respond).
//  - START: fcs high -> IDLE. READ -> DATA. Write: doe=1; ds_any -> DATA. region_req=sel from DATA entry.
//  - DATA: region_req held; fcs high -> IDLE (abort, req drops same cycle). |(region_ack & sel) -> END.
//  - END: dtack_oe=1, region_req=0; stays until fcs high -> IDLE, all outputs 0 next cycle.
//  - doe high in START/DATA/END of write cycles only; slave_active high START..END.
//  - FCS_n high in any state aborts to IDLE within SYNC_STAGES+1 cycles; reset mid-cycle releases DTACK at once.
//  - Ack arriving outside DATA or for an unselected region is ignored.
//  - err_clr and timeout in the same cycle: set wins.
// CONFIGURATION
//  Z3_TIMEOUT_EN defined: 8..16-bit counter (width from TIMEOUT_CYCLES) clears on DATA entry, counts in DATA;
//    reaching TIMEOUT_CYCLES forces END (dtack asserted), sets timeout_err.
//  Z3_TIMEOUT_EN undefined: no counter; DATA waits indefinitely for ack; timeout_err tied 0.
// STRUCTURE
//  Package z3_pkg: state encoding (Z3_IDLE=0, Z3_START=1, Z3_DATA=2, Z3_END=3), MAX_REGIONS=8,
//    function for lowest-set-bit one-hot priority select.
//  Sub-module z3_sync: parametrised WIDTH x STAGES synchroniser, async reset to 1s; instanced for {FCS_n, DS_n}.
//  FSM, decode and timeout counter live in z3_target_ctrl.
// TESTING
//  1 Read, region 2 base 28'h0900000 mask 28'hFFFFFF8, addr 28'h0900004, ack after 3 cycles
//    -> region_req=5'b00100 in DATA, dtack_oe 1 cycle after ack until FCS_n high.
//  2 Write to region 0: doe=1 in START, DATA entered only after DS_n=4'b1110 synced; ack -> dtack_oe.
//  3 Regions 1 and 3 overlap, both enabled -> only region_req[1]; disable region 1 -> region_req[3].
//  4 FCS_n raised during DATA before ack -> req drops, IDLE, dtack_oe never set, later ack ignored.
//  5 Z3_TIMEOUT_EN, TIMEOUT_CYCLES=16, no ack -> END on 16th DATA cycle, timeout_err=1 until err_clr.
//  6 FC=3'b011 or unmapped addr 28'hF000000 -> stays IDLE, all outputs 0; IORST_n low in END -> dtack_oe 0 immediately.

Source files
------------

// File: rtl/z3_pkg.sv
// Shared definitions for the Zorro III slave-cycle controller.
// Latency: none (types, constants and a combinational helper only).
// Backpressure: not applicable.
package z3_pkg;

    localparam int MAX_REGIONS = 8;

    typedef enum logic [1:0] {
        Z3_IDLE  = 2'd0,
        Z3_START = 2'd1,
        Z3_DATA  = 2'd2,
        Z3_END   = 2'd3
    } z3_state_t;

    // Isolate the lowest set bit: lowest region index wins on overlapping windows.
    function automatic logic [MAX_REGIONS-1:0] lowest_onehot(input logic [MAX_REGIONS-1:0] v);
        return v & (~v + MAX_REGIONS'(1));
    endfunction

endpackage

// File: rtl/z3_sync.sv
// Multi-flop synchroniser for asynchronous active-low bus strobes.
// Latency: STAGES clock cycles from input change to output change.
// Backpressure: none; free-running, resets to all 1s (strobes inactive).
module z3_sync #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             CLK,
    input  logic             IORST_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [STAGES-1:0][WIDTH-1:0] chain;

    // Shift the raw strobes through STAGES flops; reset to the inactive level.
    always_ff @(posedge CLK or negedge IORST_n) begin
        if (!IORST_n) begin
            chain <= '1;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/z3_target_ctrl.sv
// Zorro III slave-cycle controller: decode, one-hot region request, DTACK generation.
// Latency: claim SYNC_STAGES+1 cycles after FCS_n falls; DTACK one cycle after selected ack.
// Backpressure: DATA waits for the region ack (or the Z3_TIMEOUT_EN timeout); FCS_n high aborts.
module z3_target_ctrl
    import z3_pkg::*;
#(
    parameter int                      NUM_REGIONS    = 5,
    parameter logic [NUM_REGIONS*28-1:0] REGION_BASE  = {NUM_REGIONS{28'h0}},
    parameter logic [NUM_REGIONS*28-1:0] REGION_MASK  = {NUM_REGIONS{28'h0}},
    parameter int                      SYNC_STAGES    = 2,
    parameter int                      TIMEOUT_CYCLES = 255
) (
    input  logic                   CLK,
    input  logic                   IORST_n,
    input  logic                   FCS_n,
    input  logic [3:0]             DS_n,
    input  logic                   READ,
    input  logic [2:0]             FC,
    input  logic [27:0]            addr,
    input  logic [NUM_REGIONS-1:0] region_en,
    output logic [NUM_REGIONS-1:0] region_req,
    input  logic [NUM_REGIONS-1:0] region_ack,
    output logic                   dtack_oe,
    output logic                   doe,
    output logic                   slave_active,
    output logic                   timeout_err,
    input  logic                   err_clr
);

    z3_state_t              state_q, state_d;
    logic [NUM_REGIONS-1:0] sel_q;
    logic                   wr_q;
    logic [4:0]             sync_q;
    logic                   fcs_n_s, ds_any, valid_space, ack_sel, to_hit;
    logic [NUM_REGIONS-1:0] hit, win;
    logic [MAX_REGIONS-1:0] pri8;
    logic                   unused_bits;

    z3_sync #(.WIDTH(5), .STAGES(SYNC_STAGES)) u_sync (
        .CLK     (CLK),
        .IORST_n (IORST_n),
        .d       ({FCS_n, DS_n}),
        .q       (sync_q)
    );

    assign fcs_n_s     = sync_q[4];
    assign ds_any      = ~&sync_q[3:0];
    assign valid_space = FC[1] ^ FC[0];
    assign ack_sel     = |(region_ack & sel_q);

    // Window decode: compare only the mask-selected address bits against each base.
    always_comb begin
        hit = '0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            hit[i] = region_en[i] &&
                     (((addr ^ REGION_BASE[28*i +: 28]) & REGION_MASK[28*i +: 28]) == 28'h0);
        end
    end

    assign pri8 = lowest_onehot(MAX_REGIONS'(hit));
    assign win  = pri8[NUM_REGIONS-1:0];

    // State register plus owner/direction captured at claim time.
    always_ff @(posedge CLK or negedge IORST_n) begin
        if (!IORST_n) begin
            state_q <= Z3_IDLE;
            sel_q   <= '0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == Z3_IDLE && state_d == Z3_START) begin
                sel_q <= win;
                wr_q  <= ~READ;
            end
        end
    end

    // Next state and Moore outputs; region_req also drops as soon as synced FCS_n is high.
    always_comb begin
        state_d      = state_q;
        region_req   = '0;
        dtack_oe     = 1'b0;
        doe          = 1'b0;
        slave_active = 1'b0;
        case (state_q)
            Z3_IDLE: begin
                if (!fcs_n_s && valid_space && (|hit)) state_d = Z3_START;
            end
            Z3_START: begin
                slave_active = 1'b1;
                doe          = wr_q;
                if (fcs_n_s)                state_d = Z3_IDLE;
                else if (!wr_q || ds_any)   state_d = Z3_DATA;
            end
            Z3_DATA: begin
                slave_active = 1'b1;
                doe          = wr_q;
                if (fcs_n_s) begin
                    state_d = Z3_IDLE;
                end else begin
                    region_req = sel_q;
                    if (ack_sel || to_hit) state_d = Z3_END;
                end
            end
            Z3_END: begin
                slave_active = 1'b1;
                doe          = wr_q;
                dtack_oe     = 1'b1;
                if (fcs_n_s) state_d = Z3_IDLE;
            end
            default: state_d = Z3_IDLE;
        endcase
    end

`ifdef Z3_TIMEOUT_EN
    localparam int TW_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int TW     = (TW_RAW < 8) ? 8 : ((TW_RAW > 16) ? 16 : TW_RAW);

    logic [TW-1:0] to_cnt;
    logic          to_fire;

    assign to_hit  = (to_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign to_fire = (state_q == Z3_DATA) && !fcs_n_s && !ack_sel && to_hit;

    // Count DATA cycles; held at zero elsewhere so each DATA entry starts fresh.
    always_ff @(posedge CLK or negedge IORST_n) begin
        if (!IORST_n)                to_cnt <= '0;
        else if (state_q != Z3_DATA) to_cnt <= '0;
        else                         to_cnt <= to_cnt + 1'b1;
    end

    // Sticky error flag; a new timeout beats a simultaneous clear.
    always_ff @(posedge CLK or negedge IORST_n) begin
        if (!IORST_n)     timeout_err <= 1'b0;
        else if (to_fire) timeout_err <= 1'b1;
        else if (err_clr) timeout_err <= 1'b0;
    end

    assign unused_bits = ^{FC[2], pri8};
`else
    assign to_hit      = 1'b0;
    assign timeout_err = 1'b0;
    assign unused_bits = ^{FC[2], pri8, err_clr, TIMEOUT_CYCLES[0]};
`endif

endmodule

// File: tb/tb_z3_target_ctrl.sv
module tb_z3_target_ctrl;

    localparam int NR = 5;
    localparam logic [NR*28-1:0] BASE = {28'h0800000, 28'h0200000, 28'h0900000, 28'h0200000, 28'h0100000};
    localparam logic [NR*28-1:0] MASK = {28'hFFFF000, 28'hFFF0000, 28'hFFFFFF8, 28'hFF00000, 28'hFF00000};

    // Reference region table, index = region number.
    logic [27:0] m_base [NR] = '{28'h0100000, 28'h0200000, 28'h0900000, 28'h0200000, 28'h0800000};
    logic [27:0] m_mask [NR] = '{28'hFF00000, 28'hFF00000, 28'hFFFFFF8, 28'hFFF0000, 28'hFFFF000};

    logic          CLK = 1'b0;
    logic          IORST_n, FCS_n, READ, err_clr;
    logic [3:0]    DS_n;
    logic [2:0]    FC;
    logic [27:0]   addr;
    logic [NR-1:0] region_en, region_req, region_ack;
    logic          dtack_oe, doe, slave_active, timeout_err;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    z3_target_ctrl #(
        .NUM_REGIONS    (NR),
        .REGION_BASE    (BASE),
        .REGION_MASK    (MASK),
        .SYNC_STAGES    (2),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .CLK          (CLK),
        .IORST_n      (IORST_n),
        .FCS_n        (FCS_n),
        .DS_n         (DS_n),
        .READ         (READ),
        .FC           (FC),
        .addr         (addr),
        .region_en    (region_en),
        .region_req   (region_req),
        .region_ack   (region_ack),
        .dtack_oe     (dtack_oe),
        .doe          (doe),
        .slave_active (slave_active),
        .timeout_err  (timeout_err),
        .err_clr      (err_clr)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // {slave_active, doe, dtack_oe, region_req}
    function automatic logic [15:0] outs();
        return 16'({slave_active, doe, dtack_oe, region_req});
    endfunction

    // Owner per the decode rules: valid space, enabled, masked compare, lowest index first.
    function automatic int model_owner(input logic [27:0] a, input logic [2:0] fc, input logic [NR-1:0] en);
        if (fc[1] == fc[0]) return -1;
        for (int i = 0; i < NR; i++)
            if (en[i] && ((a & m_mask[i]) == (m_base[i] & m_mask[i]))) return i;
        return -1;
    endfunction

    // One complete bus cycle with checks of claim, request, ack and release.
    task automatic do_cycle(input string tag, input logic [27:0] a, input logic [2:0] fc,
                            input logic [NR-1:0] en, input logic rd, input int ack_dly,
                            input logic [NR-1:0] exp);
        logic [15:0] acc;
        logic [15:0] bad;
        int n;
        addr = a; FC = fc; region_en = en; READ = rd; DS_n = 4'hF; region_ack = '0;
        FCS_n = 1'b0;
        if (exp == '0) begin
            acc = '0;
            for (int k = 0; k < 7; k++) begin step(1); acc = acc | outs(); end
            chk({tag, "_noclaim"}, acc, 16'h0);
        end else begin
            n = 0;
            repeat (12) begin
                step(1);
                n++;
                if (region_req !== '0) break;
                if (n == 3) begin
                    chk({tag, "_start"}, 16'({slave_active, doe, dtack_oe}), 16'({1'b1, ~rd, 1'b0}));
                    if (!rd) DS_n = 4'($urandom_range(0, 14));
                end
            end
            chk({tag, "_lat"}, 16'(n), rd ? 16'd4 : 16'd6);
            chk({tag, "_req"}, 16'(region_req), 16'(exp));
            bad = '0;
            for (int k = 0; k < ack_dly; k++) begin
                region_ack = NR'($urandom) & ~exp;
                step(1);
                if (region_req !== exp || dtack_oe !== 1'b0) bad = 16'hBAD;
            end
            chk({tag, "_wait"}, bad, 16'h0);
            region_ack = exp;
            step(1);
            region_ack = '0;
            chk({tag, "_ack"}, outs(), 16'({1'b1, ~rd, 1'b1, {NR{1'b0}}}));
            step(2);
            FCS_n = 1'b1; DS_n = 4'hF;
            step(2);
            chk({tag, "_hold"}, 16'(dtack_oe), 16'h1);
            step(1);
        end
        FCS_n = 1'b1; DS_n = 4'hF;
        step(1);
        chk({tag, "_rel"}, outs(), 16'h0);
    endtask

    typedef struct {
        logic [27:0]   a;
        logic [2:0]    fc;
        logic [NR-1:0] en;
        logic          rd;
        int            ack_dly;
        logic [NR-1:0] exp;
    } vec_t;

    vec_t tbl [12];

    initial begin
        logic [27:0] ra;
        logic [2:0]  rfc;
        logic [NR-1:0] ren, rexp;
        logic rrd;
        int own, r;

        tbl[0]  = '{28'h0900004, 3'b001, 5'h1F, 1'b1, 3, 5'b00100};
        tbl[1]  = '{28'h0123456, 3'b010, 5'h1F, 1'b0, 1, 5'b00001};
        tbl[2]  = '{28'h0201234, 3'b001, 5'h1F, 1'b1, 0, 5'b00010};
        tbl[3]  = '{28'h0201234, 3'b001, 5'h1D, 1'b1, 2, 5'b01000};
        tbl[4]  = '{28'h0210000, 3'b001, 5'h1F, 1'b1, 1, 5'b00010};
        tbl[5]  = '{28'h0210000, 3'b001, 5'h1D, 1'b1, 1, 5'b00000};
        tbl[6]  = '{28'h0800ABC, 3'b110, 5'h1F, 1'b0, 2, 5'b10000};
        tbl[7]  = '{28'h0900004, 3'b011, 5'h1F, 1'b1, 1, 5'b00000};
        tbl[8]  = '{28'h0900004, 3'b000, 5'h1F, 1'b1, 1, 5'b00000};
        tbl[9]  = '{28'hF000000, 3'b001, 5'h1F, 1'b1, 1, 5'b00000};
        tbl[10] = '{28'h0900007, 3'b101, 5'h1F, 1'b1, 4, 5'b00100};
        tbl[11] = '{28'h0900008, 3'b001, 5'h1F, 1'b1, 1, 5'b00000};

        IORST_n = 1'b0; FCS_n = 1'b1; DS_n = 4'hF; READ = 1'b1; FC = 3'b001;
        addr = '0; region_en = '0; region_ack = '0; err_clr = 1'b0;
        step(2);
        chk("reset_outs", 16'({outs(), timeout_err}), 16'h0);
        IORST_n = 1'b1;
        step(2);

        // Directed decode table.
        for (int i = 0; i < 12; i++)
            do_cycle($sformatf("vec%0d", i), tbl[i].a, tbl[i].fc, tbl[i].en, tbl[i].rd,
                     tbl[i].ack_dly, tbl[i].exp);

        // Write: ack outside DATA ignored, waits for DS, unselected ack ignored.
        addr = 28'h0100040; FC = 3'b001; region_en = 5'h1F; READ = 1'b0; DS_n = 4'hF;
        region_ack = 5'b00001; FCS_n = 1'b0;
        step(6);
        chk("wr_start_hold", outs(), 16'({3'b110, 5'b00000}));
        region_ack = '0; DS_n = 4'b1110;
        step(2);
        chk("wr_ds_sync", 16'(region_req), 16'h0);
        step(1);
        chk("wr_data", 16'(region_req), 16'b00001);
        region_ack = 5'b11110;
        step(3);
        chk("wr_unsel_ack", outs(), 16'({3'b110, 5'b00001}));
        region_ack = 5'b00001;
        step(1);
        chk("wr_dtack", outs(), 16'({3'b111, 5'b00000}));
        region_ack = '0; FCS_n = 1'b1; DS_n = 4'hF;
        step(3);
        chk("wr_release", outs(), 16'h0);

        // Abort in DATA before ack.
        addr = 28'h0900004; READ = 1'b1; FCS_n = 1'b0;
        step(6);
        chk("abort_data", 16'(region_req), 16'b00100);
        FCS_n = 1'b1;
        step(2);
        chk("abort_req_drop", 16'({dtack_oe, region_req}), 16'h0);
        step(1);
        region_ack = 5'b00100;
        step(3);
        chk("abort_late_ack", outs(), 16'h0);
        region_ack = '0;

        // Reset while in END releases DTACK immediately.
        FCS_n = 1'b0;
        step(4);
        region_ack = 5'b00100;
        step(1);
        region_ack = '0;
        chk("rst_in_end_pre", 16'(dtack_oe), 16'h1);
        IORST_n = 1'b0;
        #1;
        chk("rst_in_end", 16'({dtack_oe, slave_active}), 16'h0);
        FCS_n = 1'b1;
        step(2);
        IORST_n = 1'b1;
        step(2);
        chk("rst_after", outs(), 16'h0);

        // No ack: timeout behaviour depends on build.
        addr = 28'h0900004; READ = 1'b1; FCS_n = 1'b0;
        step(4);
        chk("to_data", 16'(region_req), 16'b00100);
`ifdef Z3_TIMEOUT_EN
        step(15);
        chk("to_16th_data", 16'({dtack_oe, timeout_err, region_req}), 16'({2'b00, 5'b00100}));
        step(1);
        chk("to_end", 16'({dtack_oe, timeout_err, region_req}), 16'({2'b11, 5'b00000}));
        FCS_n = 1'b1;
        step(3);
        chk("to_sticky", 16'({dtack_oe, timeout_err}), 16'b01);
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;
        chk("to_clear", 16'(timeout_err), 16'h0);
`else
        step(40);
        chk("no_to_wait", 16'({dtack_oe, timeout_err, region_req}), 16'({2'b00, 5'b00100}));
        region_ack = 5'b00100;
        step(1);
        region_ack = '0;
        chk("no_to_ack", 16'(dtack_oe), 16'h1);
        FCS_n = 1'b1;
        step(3);
        chk("no_to_rel", 16'({outs(), timeout_err}), 16'h0);
`endif

        // Randomised cycles against the decode model.
        for (int t = 0; t < 40; t++) begin
            r = $urandom_range(0, NR);
            if (r < NR) ra = m_base[r] | (28'($urandom) & ~m_mask[r]);
            else        ra = 28'($urandom);
            rfc  = 3'($urandom);
            ren  = NR'($urandom);
            rrd  = 1'($urandom);
            own  = model_owner(ra, rfc, ren);
            rexp = (own < 0) ? '0 : NR'(1) << own;
            do_cycle($sformatf("rnd%0d", t), ra, rfc, ren, rrd, $urandom_range(0, 4), rexp);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
